// File: rtl/vx_dcache_responder.sv
// vx_dcache_responder
// Slave endpoint for a per-lane dcache request bundle. It accepts a batch of up
// to NUM_REQS lane requests, services the lanes one per cycle in lane-index
// order against a local word-addressed memory, and returns a single read
// response bundle that carries per-lane valid, per-lane data and one tag.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   req_valid     per-lane request valid
//   req_rw        per-lane 1 = write, 0 = read
//   req_byteen    per-lane byte enables (writes only)
//   req_addr      per-lane word address (low $clog2(MEM_WORDS) bits index memory)
//   req_data      per-lane write data
//   req_tag       per-lane tag; the tag of the lowest valid lane is kept
//   req_ready     per-lane ready, all bits equal, high only in IDLE
//   rsp_valid     per-lane read-response valid
//   rsp_data      per-lane read data, zero for lanes that did not read
//   rsp_tag       batch tag
//   rsp_ready     response consumer ready
//
// Build option
//   DCACHE_RSP_PERF_EN  adds 32-bit perf_reads, perf_writes and perf_stalls.
module vx_dcache_responder #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned WORD_SIZE  = 4,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned MEM_WORDS  = 256
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    input  logic [NUM_REQS-1:0]               req_rw,
    input  logic [NUM_REQS*WORD_SIZE-1:0]     req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0]   req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag,
    output logic [NUM_REQS-1:0]               req_ready,
    output logic [NUM_REQS-1:0]               rsp_valid,
    output logic [NUM_REQS*WORD_SIZE*8-1:0]   rsp_data,
    output logic [TAG_WIDTH-1:0]              rsp_tag,
    input  logic                              rsp_ready
`ifdef DCACHE_RSP_PERF_EN
    ,
    output logic [31:0]                       perf_reads,
    output logic [31:0]                       perf_writes,
    output logic [31:0]                       perf_stalls
`endif
);

    localparam int unsigned DATA_W = WORD_SIZE * 8;
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned LANE_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [NUM_REQS-1:0]           pend_q,      pend_d;
    logic [NUM_REQS-1:0]           rw_q,        rw_d;
    logic [NUM_REQS*WORD_SIZE-1:0] be_q,        be_d;
    logic [NUM_REQS*IDX_W-1:0]     idx_q,       idx_d;
    logic [NUM_REQS*DATA_W-1:0]    wdata_q,     wdata_d;
    logic [NUM_REQS-1:0]           rmask_q,     rmask_d;
    logic [NUM_REQS*DATA_W-1:0]    rdata_q,     rdata_d;
    logic [TAG_WIDTH-1:0]          tag_q,       tag_d;
    logic [NUM_REQS-1:0]           rsp_valid_q, rsp_valid_d;
    logic                          req_ready_q, req_ready_d;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic                      accept_c;
    logic [LANE_W-1:0]         lane_c;
    logic [NUM_REQS-1:0]       lane_oh_c;
    logic                      last_c;
    logic                      lane_wr_c;
    logic                      lane_rd_c;
    logic [NUM_REQS-1:0]       rmask_set_c;
    logic [IDX_W-1:0]          mem_idx_c;
    logic [DATA_W-1:0]         mem_rdata_c;
    logic                      mem_we_c;
    logic [WORD_SIZE-1:0]      mem_be_c;
    logic [DATA_W-1:0]         mem_wdata_c;
    logic [TAG_WIDTH-1:0]      first_tag_c;
    logic [NUM_REQS*IDX_W-1:0] req_idx_c;
    logic                      unused_addr_c;

    // Upper address bits above the memory index are intentionally ignored.
    assign unused_addr_c = ^req_addr;

    assign accept_c = (state_q == S_IDLE) && req_ready_q && (|req_valid);

    // Lowest pending lane is serviced first.
    always_comb begin
        lane_c = '0;
        for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
            if (pend_q[i]) lane_c = LANE_W'(i);
        end
    end

    // Tag of the lowest valid lane names the batch.
    always_comb begin
        first_tag_c = '0;
        for (int i = int'(NUM_REQS) - 1; i >= 0; i--) begin
            if (req_valid[i]) first_tag_c = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    always_comb begin
        req_idx_c = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            req_idx_c[i*IDX_W +: IDX_W] = req_addr[i*ADDR_WIDTH +: IDX_W];
        end
    end

    assign lane_oh_c   = NUM_REQS'(1) << lane_c;
    assign last_c      = ((pend_q & ~lane_oh_c) == '0);
    assign lane_wr_c   = (state_q == S_PROC) &&  rw_q[lane_c];
    assign lane_rd_c   = (state_q == S_PROC) && !rw_q[lane_c];
    assign rmask_set_c = rmask_q | (lane_rd_c ? lane_oh_c : '0);
    assign mem_idx_c   = idx_q[lane_c*IDX_W +: IDX_W];
    assign mem_rdata_c = mem[mem_idx_c];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_c) state_d = S_PROC;
            S_PROC: if (last_c)   state_d = (rmask_set_c != '0) ? S_RSP : S_IDLE;
            S_RSP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Batch capture, lane servicing and registered output values.
    always_comb begin
        pend_d      = pend_q;
        rw_d        = rw_q;
        be_d        = be_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rmask_d     = rmask_q;
        rdata_d     = rdata_q;
        tag_d       = tag_q;
        mem_we_c    = 1'b0;
        mem_be_c    = be_q[lane_c*WORD_SIZE +: WORD_SIZE];
        mem_wdata_c = wdata_q[lane_c*DATA_W +: DATA_W];
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    pend_d  = req_valid;
                    rw_d    = req_rw;
                    be_d    = req_byteen;
                    idx_d   = req_idx_c;
                    wdata_d = req_data;
                    tag_d   = first_tag_c;
                    rmask_d = '0;
                    rdata_d = '0;
                end
            end
            S_PROC: begin
                pend_d   = pend_q & ~lane_oh_c;
                mem_we_c = lane_wr_c;
                rmask_d  = rmask_set_c;
                if (lane_rd_c) rdata_d[lane_c*DATA_W +: DATA_W] = mem_rdata_c;
            end
            default: ;
        endcase
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RSP) ? rmask_d : '0;
    end

    // Batch and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q      <= '0;
            rw_q        <= '0;
            be_q        <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rmask_q     <= '0;
            rdata_q     <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            req_ready_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            rw_q        <= rw_d;
            be_q        <= be_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rmask_q     <= rmask_d;
            rdata_q     <= rdata_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Memory array is never reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we_c && !reset) begin
            for (int b = 0; b < int'(WORD_SIZE); b++) begin
                if (mem_be_c[b]) mem[mem_idx_c][b*8 +: 8] <= mem_wdata_c[b*8 +: 8];
            end
        end
    end

    assign req_ready = {NUM_REQS{req_ready_q}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rdata_q;
    assign rsp_tag   = tag_q;

`ifdef DCACHE_RSP_PERF_EN
    logic [31:0] perf_reads_q, perf_writes_q, perf_stalls_q;

    // Lane and stall counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (lane_rd_c) perf_reads_q  <= perf_reads_q  + 32'd1;
            if (lane_wr_c) perf_writes_q <= perf_writes_q + 32'd1;
            if ((|rsp_valid_q) && !rsp_ready) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_reads  = perf_reads_q;
    assign perf_writes = perf_writes_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_dcache_responder.sv
// Randomised bench for vx_dcache_responder against a word-array reference model.
module tb_vx_dcache_responder;
    localparam int NR = 4;
    localparam int WS = 4;
    localparam int TW = 8;
    localparam int AW = 30;
    localparam int MW = 256;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_rw;
    logic [NR*WS-1:0]     req_byteen;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*DW-1:0]     req_data;
    logic [NR*TW-1:0]     req_tag;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        rsp_valid;
    logic [NR*DW-1:0]     rsp_data;
    logic [TW-1:0]        rsp_tag;
    logic                 rsp_ready;
`ifdef DCACHE_RSP_PERF_EN
    logic [31:0]          perf_reads, perf_writes, perf_stalls;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] mdl_mem [MW];
    int m_reads  = 0;
    int m_writes = 0;
    int m_stalls = 0;

    vx_dcache_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_byteen (req_byteen),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready)
`ifdef DCACHE_RSP_PERF_EN
        ,
        .perf_reads (perf_reads),
        .perf_writes(perf_writes),
        .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [NR*AW-1:0] pack_addr(input logic [AW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [NR*DW-1:0] pack_data(input logic [DW-1:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    // Issue one batch, predict its outcome from lane-ordered semantics, and check it.
    task automatic run_batch(input logic [NR-1:0] v, input logic [NR-1:0] rw,
                             input logic [NR*WS-1:0] be, input logic [NR*AW-1:0] ad,
                             input logic [NR*DW-1:0] wd, input logic [TW-1:0] tg,
                             input int stall);
        logic [NR-1:0]    emask;
        logic [NR*DW-1:0] edata;
        logic [NR*TW-1:0] tags;
        logic [7:0]       idx;
        int               k;
        int               cyc;

        cyc = 0;
        while (req_ready != 4'hF && cyc < 50) begin
            cyc_step();
            cyc++;
        end
        chk("ready_before_batch", req_ready, 4'hF);

        for (int l = 0; l < NR; l++) tags[l*TW +: TW] = v[l] ? tg : TW'($urandom);
        req_valid  = v;
        req_rw     = rw;
        req_byteen = be;
        req_addr   = ad;
        req_data   = wd;
        req_tag    = tags;
        rsp_ready  = (stall == 0);
        cyc_step();
        req_valid  = '0;
        req_rw     = NR'($urandom);
        req_byteen = (NR*WS)'($urandom);
        req_addr   = {4{AW'($urandom)}};
        req_data   = {4{DW'($urandom)}};
        req_tag    = {4{TW'($urandom)}};

        emask = '0;
        edata = '0;
        k     = 0;
        for (int l = 0; l < NR; l++) begin
            if (v[l]) begin
                k++;
                idx = ad[l*AW +: 8];
                if (rw[l]) begin
                    m_writes++;
                    for (int b = 0; b < WS; b++)
                        if (be[l*WS + b]) mdl_mem[idx][b*8 +: 8] = wd[l*DW + b*8 +: 8];
                end else begin
                    m_reads++;
                    emask[l] = 1'b1;
                    edata[l*DW +: DW] = mdl_mem[idx];
                end
            end
        end

        cyc = 1;
        while (rsp_valid == '0 && req_ready == '0 && cyc < 20) begin
            cyc_step();
            cyc++;
        end

        if (emask != '0) begin
            chk("rsp_latency", cyc, k + 1);
            chk("rsp_valid", rsp_valid, emask);
            chk("rsp_tag", rsp_tag, tg);
            chk("rsp_data", rsp_data, edata);
            chk("ready_in_rsp", req_ready, 4'h0);
            for (int s = 0; s < stall; s++) begin
                cyc_step();
                chk("stall_hold_ctl", {rsp_valid, rsp_tag, req_ready}, {emask, tg, 4'h0});
                chk("stall_hold_data", rsp_data, edata);
            end
            m_stalls += stall;
            rsp_ready = 1'b1;
            cyc_step();
            chk("rsp_after_hs", rsp_valid, 4'h0);
            chk("ready_after_hs", req_ready, 4'hF);
        end else begin
            chk("wr_only_return", cyc, k + 1);
            chk("wr_only_no_rsp", rsp_valid, 4'h0);
            chk("wr_only_ready", req_ready, 4'hF);
        end
`ifdef DCACHE_RSP_PERF_EN
        chk("perf_reads", perf_reads, 32'(m_reads));
        chk("perf_writes", perf_writes, 32'(m_writes));
        chk("perf_stalls", perf_stalls, 32'(m_stalls));
`endif
    endtask

    initial begin
        logic [NR*AW-1:0] ad;
        logic [NR*DW-1:0] wd;
        logic [NR-1:0]    seen;
        int               stall;

        reset      = 1'b1;
        req_valid  = '0;
        req_rw     = '0;
        req_byteen = '0;
        req_addr   = '0;
        req_data   = '0;
        req_tag    = '0;
        rsp_ready  = 1'b1;
        repeat (3) cyc_step();
        chk("reset_ready", req_ready, 4'h0);
        chk("reset_rsp_valid", rsp_valid, 4'h0);
        chk("reset_rsp_tag", rsp_tag, 8'h00);
        chk("reset_rsp_data", rsp_data, 128'h0);
        reset = 1'b0;
        cyc_step();
        chk("ready_after_reset", req_ready, 4'hF);

        // Fill the whole memory so every later read has a defined expectation.
        for (int i = 0; i < MW / NR; i++) begin
            for (int l = 0; l < NR; l++) begin
                ad[l*AW +: AW] = {22'($urandom), 8'(i*NR + l)};
                wd[l*DW +: DW] = DW'($urandom);
            end
            run_batch(4'hF, 4'hF, 16'hFFFF, ad, wd, TW'($urandom), 0);
        end

        // Single write then read.
        run_batch(4'b0001, 4'b0001, 16'h000F, pack_addr(30'd5, 30'd0, 30'd0, 30'd0),
                  pack_data(32'hDEADBEEF, 32'h0, 32'h0, 32'h0), 8'h00, 0);
        run_batch(4'b0100, 4'b0000, 16'h0000, pack_addr(30'd0, 30'd0, 30'd5, 30'd0),
                  '0, 8'h3C, 0);

        // Full read batch of preloaded words.
        run_batch(4'hF, 4'hF, 16'hFFFF, pack_addr(30'd1, 30'd2, 30'd3, 30'd4),
                  pack_data(32'h11, 32'h22, 32'h33, 32'h44), 8'h01, 0);
        run_batch(4'hF, 4'h0, 16'h0000, pack_addr(30'd1, 30'd2, 30'd3, 30'd4), '0, 8'h02, 0);

        // Partial write followed by a same-address read in a higher lane.
        run_batch(4'b0001, 4'b0001, 16'h000F, pack_addr(30'd9, 30'd0, 30'd0, 30'd0),
                  pack_data(32'h12345678, 32'h0, 32'h0, 32'h0), 8'h03, 0);
        run_batch(4'b1010, 4'b0010, 16'h0030, pack_addr(30'd0, 30'd9, 30'd0, 30'd9),
                  pack_data(32'h0, 32'hAAAAAAAA, 32'h0, 32'h0), 8'h04, 0);

        // Backpressure for six cycles.
        run_batch(4'b0110, 4'b0000, 16'h0000, pack_addr(30'd7, 30'd8, 30'd9, 30'd10), '0, 8'h5A, 6);

        // Write-only pair.
        run_batch(4'b0011, 4'b0011, 16'h00FF, pack_addr(30'd20, 30'd21, 30'd0, 30'd0),
                  pack_data(32'hCAFE0001, 32'hCAFE0002, 32'h0, 32'h0), 8'h06, 0);

        // Reset during the second PROC cycle of a four-lane read.
        req_valid = 4'hF;
        req_rw    = 4'h0;
        req_addr  = pack_addr(30'd1, 30'd2, 30'd3, 30'd4);
        req_tag   = {4{8'h55}};
        rsp_ready = 1'b1;
        cyc_step();
        req_valid = '0;
        chk("rst_mid_ready_proc", req_ready, 4'h0);
        cyc_step();
        reset = 1'b1;
        cyc_step();
        chk("rst_mid_ready_in_reset", req_ready, 4'h0);
        chk("rst_mid_valid_in_reset", rsp_valid, 4'h0);
        cyc_step();
        reset = 1'b0;
        m_reads  = 0;
        m_writes = 0;
        m_stalls = 0;
        cyc_step();
        chk("rst_mid_ready_after", req_ready, 4'hF);
        chk("rst_mid_tag_after", rsp_tag, 8'h00);
        chk("rst_mid_data_after", rsp_data, 128'h0);
        seen = '0;
        for (int i = 0; i < 6; i++) begin
            seen |= rsp_valid;
            cyc_step();
        end
        chk("rst_mid_no_rsp", seen, 4'h0);
`ifdef DCACHE_RSP_PERF_EN
        chk("perf_reads_reset", perf_reads, 32'd0);
`endif

        // Random batches, often aliasing a few addresses to exercise ordering.
        for (int t = 0; t < 40; t++) begin
            for (int l = 0; l < NR; l++) begin
                if ($urandom_range(0, 1) == 0) ad[l*AW +: AW] = {22'($urandom), 8'($urandom_range(0, 3))};
                else                           ad[l*AW +: AW] = AW'($urandom);
                wd[l*DW +: DW] = DW'($urandom);
            end
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_batch(NR'($urandom_range(1, 15)), NR'($urandom), (NR*WS)'($urandom),
                      ad, wd, TW'($urandom), stall);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
